alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Two-requester controller that shares one 8-bit ALU (alu_8) between two clients.
- Round-robin arbitration, opcode legality check and operand registering.
- Drives the ALU from registered operands and returns a tagged, held result over a valid/ready response channel.
- Sits between client blocks (sequencers, test drivers) and the single shared ALU instance.

Parameters:
PRIO_RESET, 0, requester index favoured on the first arbitration after reset (0 or 1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_op  input  4  requester 0 opcode (ALU encoding).
req0_a  input  8  requester 0 operand A.
req0_b  input  8  requester 0 operand B.
req1_valid  input  1  requester 1 has an operation.
req1_ready  output  1  requester 1 operation accepted this cycle.
req1_op  input  4  requester 1 opcode.
req1_a  input  8  requester 1 operand A.
req1_b  input  8  requester 1 operand B.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer takes response.
rsp_id  output  1  index of requester that issued the operation.
rsp_out  output  8  ALU result.
rsp_cout  output  1  ALU carry/borrow.
rsp_err  output  1  opcode was illegal; rsp_out=0, rsp_cout=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State=IDLE.
  - rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_err are all 0.
  - Operand registers are 0.
  - Last-grant pointer = ~PRIO_RESET.
- Opcodes:
  - Legal: 0111 add, 0110 sub, 0101 inc, 0100 dec, 1111 and, 1110 or, 1101 not, 1100 xor.
  - Illegal: 0000-0011 and 1000-1011. An illegal opcode is never presented to the ALU. The ALU opcode register is loaded with 1100 instead, and err_q is set.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any reqN_valid, grant one requester.
    - If only one is valid, grant it.
    - If both are valid, grant the requester that is not the last-grant pointer.
    - reqN_ready=1 combinationally for the granted requester only, in that cycle.
    - At the clock edge: latch op/a/b/err into registers, latch rsp id, update the pointer to the granted index, go to EXEC.
    - No valid: stay in IDLE, both readies 0.
  - EXEC: the ALU (en tied 1) sees the registered a/b/op.
    - At the edge: capture out/cout into rsp regs. Force 0/0 if err_q. Set rsp_err=err_q and rsp_valid=1. Go to RESP.
  - RESP: hold every rsp_* output stable while rsp_valid=1 and rsp_ready=0.
    - On rsp_valid&&rsp_ready: clear rsp_valid at the edge, go to IDLE. rsp_out/rsp_cout/rsp_id/rsp_err keep their last values.
  - Both readies are 0 in EXEC and RESP.
- Latency and throughput:
  - Accept cycle N gives rsp_valid high from cycle N+2.
  - Minimum issue interval is 3 cycles; there is no back-to-back issue.
- Width rules: inc/dec ignore B. not ignores B, cout=0. Logic ops give cout=0. add cout = carry out of bit 7. Sub cout follows sub8 with cin=0.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1… starting with PRIO_RESET.
- A requester dropping valid before its grant loses nothing. No request is queued inside the block.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded and no response is produced. All outputs return to reset values asynchronously.
- Operand/op changes on a requester after acceptance have no effect on the in-flight op.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_ADD=4'b0111, OP_SUB=4'b0110, OP_INC=4'b0101, OP_DEC=4'b0100, OP_AND=4'b1111, OP_OR=4'b1110, OP_NOT=4'b1101, OP_XOR=4'b1100.
  - State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - An opcode-legality function.
- One sub-module: the existing alu_8, instantiated once, en tied 1.
- Arbiter and FSM live in this module.

Test Plan:
- Reset, then req0 add a=8'hF0 b=8'h20, rsp_ready=1 -> rsp_valid at accept+2, rsp_id=0, rsp_out=8'h10, rsp_cout=1, rsp_err=0.
- Both requesters valid continuously: req0 inc a=8'hFF, req1 xor a=8'hAA b=8'h0F -> grants alternate 0,1,0 (PRIO_RESET=0). Responses: id0 out=8'h00 cout=1; id1 out=8'hA5 cout=0.
- req1 op=4'b0010 a=8'h55 -> rsp_err=1, rsp_out=8'h00, rsp_cout=0, rsp_id=1.
- rsp_ready held 0 for 5 cycles after rsp_valid with req0 dec a=8'h00 -> outputs stable, req0/req1 ready stay 0. On release: one handshake, then return to IDLE.
- Change req0_a from 8'h01 to 8'h7F in the cycle after acceptance of not a=8'h01 -> rsp_out=8'hFE.
- Assert rst during EXEC of req1 and a=8'h0F b=8'hF3 -> rsp_valid never rises. Post-reset, the first grant goes to PRIO_RESET when both are valid.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and opcode legality for the shared-ALU controller.
package alu_share_ctrl_pkg;

   localparam logic [3:0] OP_ADD = 4'b0111;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_INC = 4'b0101;
   localparam logic [3:0] OP_DEC = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b1111;
   localparam logic [3:0] OP_OR  = 4'b1110;
   localparam logic [3:0] OP_NOT = 4'b1101;
   localparam logic [3:0] OP_XOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_INC, OP_DEC,
         OP_AND, OP_OR, OP_NOT, OP_XOR: ok = 1'b1;
         default:                       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between two clients and the shared-ALU controller.
interface alu_share_ctrl_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [3:0] req0_op;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic       req1_valid;
   logic       req1_ready;
   logic [3:0] req1_op;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_out;
   logic       rsp_cout;
   logic       rsp_err;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_err
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_err
   );
endinterface

// File: rtl/alu_share_ctrl_alu8.sv
// Combinational 8-bit ALU; cout is carry for add/inc and borrow for sub/dec, 0 for logic ops.
module alu_8
   import alu_share_ctrl_pkg::*;
(
   input  logic       en,
   input  logic [3:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] out,
   output logic       cout
);

   logic [8:0] res;

   always_comb begin
      res = 9'd0;
      case (op)
         OP_ADD:  res = {1'b0, a} + {1'b0, b};
         OP_SUB:  res = {1'b0, a} - {1'b0, b};
         OP_INC:  res = {1'b0, a} + 9'd1;
         OP_DEC:  res = {1'b0, a} - 9'd1;
         OP_AND:  res = {1'b0, a & b};
         OP_OR:   res = {1'b0, a | b};
         OP_NOT:  res = {1'b0, ~a};
         OP_XOR:  res = {1'b0, a ^ b};
         default: res = 9'd0;
      endcase
   end

   assign out  = en ? res[7:0] : 8'd0;
   assign cout = en ? res[8]   : 1'b0;

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one alu_8 between two requesters.
//   state | meaning
//   IDLE  | waiting for a request; grant one, latch its operands
//   EXEC  | ALU evaluates registered operands; result captured at the edge
//   RESP  | response held until the consumer takes it
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter bit PRIO_RESET = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   alu_share_ctrl_if.slave  bus
);

   state_t     state_q;
   logic       last_q;
   logic [3:0] op_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic       err_q;
   logic       rsp_valid_q;
   logic       rsp_id_q;
   logic [7:0] rsp_out_q;
   logic       rsp_cout_q;
   logic       rsp_err_q;

   logic       gnt0;
   logic       gnt1;
   logic [3:0] sel_op;
   logic [7:0] sel_a;
   logic [7:0] sel_b;
   logic       sel_legal;
   logic [7:0] alu_out;
   logic       alu_cout;

   // On contention the requester that did not win last time gets the grant.
   assign gnt0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_q);
   assign gnt1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_q);

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   assign sel_op    = gnt1 ? bus.req1_op : bus.req0_op;
   assign sel_a     = gnt1 ? bus.req1_a  : bus.req0_a;
   assign sel_b     = gnt1 ? bus.req1_b  : bus.req0_b;
   assign sel_legal = op_legal(sel_op);

   alu_8 u_alu (
      .en   (1'b1),
      .op   (op_q),
      .a    (a_q),
      .b    (b_q),
      .out  (alu_out),
      .cout (alu_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= ~PRIO_RESET;
         op_q        <= 4'd0;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_out_q   <= 8'd0;
         rsp_cout_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  // Illegal opcodes are replaced by a harmless XOR; the result is zeroed later.
                  op_q     <= sel_legal ? sel_op : OP_XOR;
                  err_q    <= ~sel_legal;
                  a_q      <= sel_a;
                  b_q      <= sel_b;
                  rsp_id_q <= gnt1;
                  last_q   <= gnt1;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               rsp_out_q   <= err_q ? 8'd0 : alu_out;
               rsp_cout_q  <= err_q ? 1'b0 : alu_cout;
               rsp_err_q   <= err_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_out   = rsp_out_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with hand-computed expected responses.
module tb_alu_share_ctrl;
   import alu_share_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   alu_share_ctrl_if bus();

   alu_share_ctrl #(.PRIO_RESET(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = 8'd0; bus.req0_b = 8'd0;
      bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      bus.rsp_ready = 1'b0;
      step(); step();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL reset_id: got %b expected 0", bus.rsp_id); end
      n_cmp++; if (bus.rsp_out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h expected 00", bus.rsp_out); end
      n_cmp++; if (bus.rsp_cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b expected 0", bus.rsp_cout); end
      n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", bus.rsp_err); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_add;
      bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 8'hF0; bus.req0_b = 8'h20;
      bus.rsp_ready = 1'b1;
      #1;
      n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready0: got %b expected 1", bus.req0_ready); end
      n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL add_ready1: got %b expected 0", bus.req1_ready); end
      step();
      bus.req0_valid = 1'b0;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_early_valid: got %b expected 0", bus.rsp_valid); end
      n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL add_exec_ready0: got %b expected 0", bus.req0_ready); end
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b expected 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL add_id: got %b expected 0", bus.rsp_id); end
      n_cmp++; if (bus.rsp_out !== 8'h10) begin n_bad++; $display("FAIL add_out: got %h expected 10", bus.rsp_out); end
      n_cmp++; if (bus.rsp_cout !== 1'b1) begin n_bad++; $display("FAIL add_cout: got %b expected 1", bus.rsp_cout); end
      n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL add_err: got %b expected 0", bus.rsp_err); end
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_clear: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_fairness;
      logic       exp_id;
      logic [7:0] exp_out;
      logic       exp_cout;
      int         n;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      bus.req0_valid = 1'b1; bus.req0_op = OP_INC; bus.req0_a = 8'hFF; bus.req0_b = 8'h00;
      bus.req1_valid = 1'b1; bus.req1_op = OP_XOR; bus.req1_a = 8'hAA; bus.req1_b = 8'h0F;
      bus.rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         exp_id   = (k == 1);
         exp_out  = exp_id ? 8'hA5 : 8'h00;
         exp_cout = ~exp_id;
         n = 0;
         while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin step(); n++; end
         n_cmp++; if (n >= 8) begin n_bad++; $display("FAIL fair_grant_timeout[%0d]: waited %0d cycles, limit 8", k, n); end
         n_cmp++; if (bus.req0_ready !== ~exp_id) begin n_bad++; $display("FAIL fair_ready0[%0d]: got %b expected %b", k, bus.req0_ready, ~exp_id); end
         n_cmp++; if (bus.req1_ready !== exp_id) begin n_bad++; $display("FAIL fair_ready1[%0d]: got %b expected %b", k, bus.req1_ready, exp_id); end
         step(); step();
         n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL fair_valid[%0d]: got %b expected 1", k, bus.rsp_valid); end
         n_cmp++; if (bus.rsp_id !== exp_id) begin n_bad++; $display("FAIL fair_id[%0d]: got %b expected %b", k, bus.rsp_id, exp_id); end
         n_cmp++; if (bus.rsp_out !== exp_out) begin n_bad++; $display("FAIL fair_out[%0d]: got %h expected %h", k, bus.rsp_out, exp_out); end
         n_cmp++; if (bus.rsp_cout !== exp_cout) begin n_bad++; $display("FAIL fair_cout[%0d]: got %b expected %b", k, bus.rsp_cout, exp_cout); end
         step();
      end
      idle_inputs();
      step(); step(); step();
   endtask

   task automatic test_illegal;
      bus.req1_valid = 1'b1; bus.req1_op = 4'b0010; bus.req1_a = 8'h55; bus.req1_b = 8'h33;
      bus.rsp_ready = 1'b1;
      #1;
      n_cmp++; if (bus.req1_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready1: got %b expected 1", bus.req1_ready); end
      step();
      bus.req1_valid = 1'b0;
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL ill_valid: got %b expected 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b expected 1", bus.rsp_err); end
      n_cmp++; if (bus.rsp_out !== 8'h00) begin n_bad++; $display("FAIL ill_out: got %h expected 00", bus.rsp_out); end
      n_cmp++; if (bus.rsp_cout !== 1'b0) begin n_bad++; $display("FAIL ill_cout: got %b expected 0", bus.rsp_cout); end
      n_cmp++; if (bus.rsp_id !== 1'b1) begin n_bad++; $display("FAIL ill_id: got %b expected 1", bus.rsp_id); end
      step();
   endtask

   task automatic test_hold;
      bus.req0_valid = 1'b1; bus.req0_op = OP_DEC; bus.req0_a = 8'h00; bus.req0_b = 8'h99;
      bus.rsp_ready = 1'b0;
      #1;
      n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL hold_accept: got %b expected 1", bus.req0_ready); end
      step();
      bus.req1_valid = 1'b1; bus.req1_op = OP_OR; bus.req1_a = 8'h01; bus.req1_b = 8'h02;
      step();
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus.rsp_valid); end
         n_cmp++; if (bus.rsp_out !== 8'hFF) begin n_bad++; $display("FAIL hold_out[%0d]: got %h expected ff", i, bus.rsp_out); end
         n_cmp++; if (bus.rsp_cout !== 1'b1) begin n_bad++; $display("FAIL hold_cout[%0d]: got %b expected 1", i, bus.rsp_cout); end
         n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL hold_id[%0d]: got %b expected 0", i, bus.rsp_id); end
         n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_bad++; $display("FAIL hold_readies[%0d]: got %b%b expected 00", i, bus.req0_ready, bus.req1_ready); end
         step();
      end
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_still_valid: got %b expected 1", bus.rsp_valid); end
      idle_inputs();
      bus.rsp_ready = 1'b1;
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %b expected 0", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_out !== 8'hFF) begin n_bad++; $display("FAIL hold_out_kept: got %h expected ff", bus.rsp_out); end
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_single_hs: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_operand_change;
      bus.req0_valid = 1'b1; bus.req0_op = OP_NOT; bus.req0_a = 8'h01; bus.req0_b = 8'h00;
      bus.rsp_ready = 1'b1;
      #1;
      n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL not_ready0: got %b expected 1", bus.req0_ready); end
      step();
      bus.req0_valid = 1'b0; bus.req0_a = 8'h7F;
      step();
      n_cmp++; if (bus.rsp_out !== 8'hFE) begin n_bad++; $display("FAIL not_out: got %h expected fe", bus.rsp_out); end
      n_cmp++; if (bus.rsp_cout !== 1'b0) begin n_bad++; $display("FAIL not_cout: got %b expected 0", bus.rsp_cout); end
      step();
      idle_inputs();
   endtask

   task automatic test_reset_mid;
      bus.req1_valid = 1'b1; bus.req1_op = OP_AND; bus.req1_a = 8'h0F; bus.req1_b = 8'hF3;
      bus.rsp_ready = 1'b1;
      #1;
      n_cmp++; if (bus.req1_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready1: got %b expected 1", bus.req1_ready); end
      step();
      rst = 1'b1;
      bus.req1_valid = 1'b0;
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid_async: got %b expected 0", bus.rsp_valid); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_rsp[%0d]: got %b expected 0", i, bus.rsp_valid); end
      end
      bus.req0_valid = 1'b1; bus.req0_op = OP_INC; bus.req0_a = 8'h01;
      bus.req1_valid = 1'b1; bus.req1_op = OP_INC; bus.req1_a = 8'h02;
      #1;
      n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_prio_ready0: got %b expected 1", bus.req0_ready); end
      n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_prio_ready1: got %b expected 0", bus.req1_ready); end
      idle_inputs();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation exceeded 100000 time units");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_add();
      test_fairness();
      test_illegal();
      test_hold();
      test_operand_change();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
